// File: rtl/tlb_op_pkg.sv
// Shared definitions for the TLB-maintenance sequencer: op codes, entry layout,
// ELO bit positions, FSM states and the write-entry packing helper.
package tlb_op_pkg;

  localparam int TLB_ENTRY_W = 89;

  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } tlb_op_e;

  localparam logic [2:0] INV_OP_ILLEGAL = 3'd7;

  localparam int ELO_V   = 0;
  localparam int ELO_D   = 1;
  localparam int ELO_PLV = 2;
  localparam int ELO_MAT = 4;
  localparam int ELO_G   = 6;
  localparam int ELO_PPN = 8;
  localparam int PPN_W   = 20;

  // Packed entry, LSB first: odd page, even page, then the shared tag fields.
  localparam int ENT_V1   = 0;
  localparam int ENT_D1   = 1;
  localparam int ENT_PLV1 = 2;
  localparam int ENT_MAT1 = 4;
  localparam int ENT_PFN1 = 6;
  localparam int ENT_V0   = 26;
  localparam int ENT_D0   = 27;
  localparam int ENT_PLV0 = 28;
  localparam int ENT_MAT0 = 30;
  localparam int ENT_PFN0 = 32;
  localparam int ENT_G    = 52;
  localparam int ENT_E    = 53;
  localparam int ENT_PS   = 54;
  localparam int ENT_ASID = 60;
  localparam int ENT_VPN2 = 70;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } tlb_state_e;

  function automatic logic [TLB_ENTRY_W-1:0] build_entry(
    input logic [18:0] vppn,
    input logic [9:0]  asid,
    input logic [5:0]  ps,
    input logic        refill,
    input logic        ne,
    input logic [31:0] elo0,
    input logic [31:0] elo1
  );
    logic [TLB_ENTRY_W-1:0] ent;
    ent = '0;
    ent[ENT_VPN2 +: 19]    = vppn;
    ent[ENT_ASID +: 10]    = asid;
    ent[ENT_PS +: 6]       = ps;
    ent[ENT_E]             = refill | ~ne;
    ent[ENT_G]             = elo0[ELO_G] & elo1[ELO_G];
    ent[ENT_PFN0 +: PPN_W] = elo0[ELO_PPN +: PPN_W];
    ent[ENT_MAT0 +: 2]     = elo0[ELO_MAT +: 2];
    ent[ENT_PLV0 +: 2]     = elo0[ELO_PLV +: 2];
    ent[ENT_D0]            = elo0[ELO_D];
    ent[ENT_V0]            = elo0[ELO_V];
    ent[ENT_PFN1 +: PPN_W] = elo1[ELO_PPN +: PPN_W];
    ent[ENT_MAT1 +: 2]     = elo1[ELO_MAT +: 2];
    ent[ENT_PLV1 +: 2]     = elo1[ELO_PLV +: 2];
    ent[ENT_D1]            = elo1[ELO_D];
    ent[ENT_V1]            = elo1[ELO_V];
    return ent;
  endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Command, CSR, TLB-port and result bundle of tlb_op_ctrl.
// slave = sequencer side, master = execute stage / TLB / CSR file side.
interface tlb_op_ctrl_if #(parameter int TLBNUM = 32);
  import tlb_op_pkg::*;
  localparam int IW = $clog2(TLBNUM);

  logic                   flush;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2:0]             cmd_op;
  logic [2:0]             cmd_inv_op;
  logic [9:0]             cmd_inv_asid;
  logic [31:0]            cmd_inv_vaddr;
  logic [IW-1:0]          csr_tlbidx_index;
  logic [5:0]             csr_tlbidx_ps;
  logic                   csr_tlbidx_ne;
  logic [18:0]            csr_tlbehi_vppn;
  logic [9:0]             csr_asid;
  logic [31:0]            csr_tlbelo0;
  logic [31:0]            csr_tlbelo1;
  logic                   csr_tlbrefill;
  logic                   tlb_we;
  logic                   tlb_fill_mode;
  logic [IW-1:0]          tlb_w_index;
  logic [IW-1:0]          tlb_f_index;
  logic [TLB_ENTRY_W-1:0] tlb_w_entry;
  logic [IW-1:0]          tlb_r_index;
  logic                   tlb_check_mode;
  logic [18:0]            tlb_s_vpn2;
  logic [9:0]             tlb_s_asid;
  logic                   tlb_inv_valid;
  logic [2:0]             tlb_inv_op;
  logic [31:0]            tlb_inv_vaddr;
  logic [9:0]             tlb_inv_asid;
  logic [TLB_ENTRY_W-1:0] tlb_r_entry;
  logic [IW-1:0]          tlb_s_index;
  logic                   tlb_rs_e;
  logic                   res_valid;
  logic [2:0]             res_op;
  logic                   res_err;
  logic                   res_ne;
  logic [IW-1:0]          res_index;
  logic [TLB_ENTRY_W-1:0] res_entry;

  modport slave (
    input  flush, cmd_valid, cmd_op, cmd_inv_op, cmd_inv_asid, cmd_inv_vaddr,
           csr_tlbidx_index, csr_tlbidx_ps, csr_tlbidx_ne, csr_tlbehi_vppn, csr_asid,
           csr_tlbelo0, csr_tlbelo1, csr_tlbrefill, tlb_r_entry, tlb_s_index, tlb_rs_e,
    output cmd_ready, tlb_we, tlb_fill_mode, tlb_w_index, tlb_f_index, tlb_w_entry,
           tlb_r_index, tlb_check_mode, tlb_s_vpn2, tlb_s_asid, tlb_inv_valid,
           tlb_inv_op, tlb_inv_vaddr, tlb_inv_asid, res_valid, res_op, res_err,
           res_ne, res_index, res_entry
  );

  modport master (
    output flush, cmd_valid, cmd_op, cmd_inv_op, cmd_inv_asid, cmd_inv_vaddr,
           csr_tlbidx_index, csr_tlbidx_ps, csr_tlbidx_ne, csr_tlbehi_vppn, csr_asid,
           csr_tlbelo0, csr_tlbelo1, csr_tlbrefill, tlb_r_entry, tlb_s_index, tlb_rs_e,
    input  cmd_ready, tlb_we, tlb_fill_mode, tlb_w_index, tlb_f_index, tlb_w_entry,
           tlb_r_index, tlb_check_mode, tlb_s_vpn2, tlb_s_asid, tlb_inv_valid,
           tlb_inv_op, tlb_inv_vaddr, tlb_inv_asid, res_valid, res_op, res_err,
           res_ne, res_index, res_entry
  );

endinterface

// File: rtl/tlb_fill_index_gen.sv
// Free-running TLBFILL victim index. TLB_FILL_LFSR_EN selects a 16-bit Galois
// LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1); otherwise a wrapping counter.
module tlb_fill_index_gen #(
  parameter int TLBNUM = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [$clog2(TLBNUM)-1:0] idx
);
  localparam int IW = $clog2(TLBNUM);

`ifdef TLB_FILL_LFSR_EN
  logic [15:0] r_lfsr;

  // Right-shifting Galois form: taps 16,14,13,11 map to mask 16'hB400.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign idx = r_lfsr[IW-1:0];
`else
  logic [IW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign idx = r_cnt;
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: one command at a time through
// IDLE->ISSUE->(WAIT)->DONE. Fill index source chosen by TLB_FILL_LFSR_EN.
module tlb_op_ctrl
  import tlb_op_pkg::*;
#(
  parameter int TLBNUM = 32
) (
  input  logic         clk,
  input  logic         rst,
  tlb_op_ctrl_if.slave io_tlb
);
  localparam int IW = $clog2(TLBNUM);

  tlb_state_e             r_state;
  tlb_state_e             w_state_next;
  logic [2:0]             r_op;
  logic [2:0]             r_inv_op;
  logic [9:0]             r_inv_asid;
  logic [31:0]            r_inv_vaddr;
  logic [IW-1:0]          r_index;
  logic [TLB_ENTRY_W-1:0] r_w_entry;
  logic                   r_res_ne;
  logic [IW-1:0]          r_res_index;
  logic [TLB_ENTRY_W-1:0] r_res_entry;
  logic [IW-1:0]          w_fill_idx;
  logic                   w_accept;
  logic                   w_illegal;
  logic                   w_flush;
  logic                   w_rd_e;

  tlb_fill_index_gen #(.TLBNUM(TLBNUM)) u_fill_idx (
    .clk (clk),
    .rst (rst),
    .idx (w_fill_idx)
  );

  assign w_accept  = (r_state == ST_IDLE) && io_tlb.cmd_valid;
  assign w_illegal = (r_op > 3'd4) || ((r_op == OP_INV) && (r_inv_op == INV_OP_ILLEGAL));
  assign w_flush   = io_tlb.flush && (r_state != ST_IDLE);
  assign w_rd_e    = io_tlb.tlb_r_entry[ENT_E];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_inv_op    <= '0;
      r_inv_asid  <= '0;
      r_inv_vaddr <= '0;
      r_index     <= '0;
      r_w_entry   <= '0;
      r_res_ne    <= 1'b0;
      r_res_index <= '0;
      r_res_entry <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op        <= io_tlb.cmd_op;
        r_inv_op    <= io_tlb.cmd_inv_op;
        r_inv_asid  <= io_tlb.cmd_inv_asid;
        r_inv_vaddr <= io_tlb.cmd_inv_vaddr;
        r_index     <= io_tlb.csr_tlbidx_index;
        r_w_entry   <= build_entry(io_tlb.csr_tlbehi_vppn, io_tlb.csr_asid,
                                   io_tlb.csr_tlbidx_ps, io_tlb.csr_tlbrefill,
                                   io_tlb.csr_tlbidx_ne, io_tlb.csr_tlbelo0,
                                   io_tlb.csr_tlbelo1);
        r_res_ne    <= 1'b0;
        r_res_index <= '0;
        r_res_entry <= '0;
      end
      // Only RD and SRCH reach WAIT; the TLB return is valid in this cycle.
      if (r_state == ST_WAIT) begin
        if (r_op == OP_SRCH) begin
          r_res_ne    <= ~io_tlb.tlb_rs_e;
          r_res_index <= io_tlb.tlb_rs_e ? io_tlb.tlb_s_index : '0;
        end else begin
          r_res_ne    <= ~w_rd_e;
          r_res_entry <= w_rd_e ? io_tlb.tlb_r_entry : '0;
        end
      end
    end
  end

  always_comb begin
    w_state_next          = r_state;
    io_tlb.cmd_ready      = 1'b0;
    io_tlb.tlb_we         = 1'b0;
    io_tlb.tlb_fill_mode  = 1'b0;
    io_tlb.tlb_w_index    = '0;
    io_tlb.tlb_f_index    = '0;
    io_tlb.tlb_w_entry    = '0;
    io_tlb.tlb_r_index    = '0;
    io_tlb.tlb_check_mode = 1'b0;
    io_tlb.tlb_s_vpn2     = '0;
    io_tlb.tlb_s_asid     = '0;
    io_tlb.tlb_inv_valid  = 1'b0;
    io_tlb.tlb_inv_op     = '0;
    io_tlb.tlb_inv_vaddr  = '0;
    io_tlb.tlb_inv_asid   = '0;
    io_tlb.res_valid      = 1'b0;
    io_tlb.res_op         = '0;
    io_tlb.res_err        = 1'b0;
    io_tlb.res_ne         = 1'b0;
    io_tlb.res_index      = '0;
    io_tlb.res_entry      = '0;
    unique case (r_state)
      ST_IDLE: begin
        io_tlb.cmd_ready = ~rst;
        if (io_tlb.cmd_valid) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_next = ST_DONE;
        if (!w_illegal) begin
          case (r_op)
            OP_WR: begin
              io_tlb.tlb_we      = 1'b1;
              io_tlb.tlb_w_index = r_index;
              io_tlb.tlb_w_entry = r_w_entry;
            end
            OP_FILL: begin
              io_tlb.tlb_we        = 1'b1;
              io_tlb.tlb_fill_mode = 1'b1;
              io_tlb.tlb_f_index   = w_fill_idx;
              io_tlb.tlb_w_entry   = r_w_entry;
            end
            OP_INV: begin
              io_tlb.tlb_inv_valid = 1'b1;
              io_tlb.tlb_inv_op    = r_inv_op;
              io_tlb.tlb_inv_vaddr = r_inv_vaddr;
              io_tlb.tlb_inv_asid  = r_inv_asid;
            end
            OP_RD: begin
              io_tlb.tlb_r_index = r_index;
              w_state_next       = ST_WAIT;
            end
            OP_SRCH: begin
              io_tlb.tlb_s_vpn2     = r_w_entry[ENT_VPN2 +: 19];
              io_tlb.tlb_s_asid     = r_w_entry[ENT_ASID +: 10];
              io_tlb.tlb_check_mode = 1'b1;
              w_state_next          = ST_WAIT;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: w_state_next = ST_DONE;
      ST_DONE: begin
        io_tlb.res_valid = 1'b1;
        io_tlb.res_op    = r_op;
        io_tlb.res_err   = w_illegal;
        io_tlb.res_ne    = r_res_ne;
        io_tlb.res_index = r_res_index;
        io_tlb.res_entry = r_res_entry;
        w_state_next     = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    // A flush kills this cycle's strobes and result and abandons the command.
    if (w_flush) begin
      io_tlb.tlb_we        = 1'b0;
      io_tlb.tlb_inv_valid = 1'b0;
      io_tlb.res_valid     = 1'b0;
      w_state_next         = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Randomized self-checking bench for tlb_op_ctrl against a transaction-level model.
module tb_tlb_op_ctrl;
  import tlb_op_pkg::*;

  localparam int TLBNUM = 32;
  localparam int IW     = $clog2(TLBNUM);
  localparam int EW     = TLB_ENTRY_W;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [9:0]  asid;
    logic [5:0]  ps;
    logic        e;
    logic        g;
    logic [19:0] pfn0;
    logic [1:0]  mat0;
    logic [1:0]  plv0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [1:0]  mat1;
    logic [1:0]  plv1;
    logic        d1;
    logic        v1;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlb_op_ctrl_if #(.TLBNUM(TLBNUM)) bus ();

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_tlb (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  int unsigned n_edges = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] rand_ent();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[EW-1:0];
  endfunction

  // Expected victim index after n clock edges out of reset.
  function automatic logic [IW-1:0] exp_fill(input int unsigned n);
`ifdef TLB_FILL_LFSR_EN
    logic [15:0] s;
    s = 16'hACE1;
    for (int unsigned i = 0; i < n; i++) begin
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
    return s[IW-1:0];
`else
    return IW'(n % TLBNUM);
`endif
  endfunction

  function automatic logic [EW-1:0] exp_entry(input logic [18:0] vppn, input logic [9:0] asid,
                                              input logic [5:0] ps, input logic ne,
                                              input logic refill, input logic [31:0] lo0,
                                              input logic [31:0] lo1);
    ent_t x;
    x.vpn2 = vppn;       x.asid = asid;       x.ps   = ps;
    x.e    = refill || !ne;
    x.g    = lo0[6] && lo1[6];
    x.pfn0 = lo0[27:8];  x.mat0 = lo0[5:4];   x.plv0 = lo0[3:2];
    x.d0   = lo0[1];     x.v0   = lo0[0];
    x.pfn1 = lo1[27:8];  x.mat1 = lo1[5:4];   x.plv1 = lo1[3:2];
    x.d1   = lo1[1];     x.v1   = lo1[0];
    return x;
  endfunction

  task automatic rand_csr();
    bus.cmd_inv_op       = 3'($urandom);
    bus.cmd_inv_asid     = 10'($urandom);
    bus.cmd_inv_vaddr    = $urandom;
    bus.csr_tlbidx_index = IW'($urandom);
    bus.csr_tlbidx_ps    = 6'($urandom);
    bus.csr_tlbidx_ne    = 1'($urandom);
    bus.csr_tlbehi_vppn  = 19'($urandom);
    bus.csr_asid         = 10'($urandom);
    bus.csr_tlbelo0      = $urandom;
    bus.csr_tlbelo1      = $urandom;
    bus.csr_tlbrefill    = 1'($urandom);
  endtask

  // Issue one command from IDLE and follow it to its result.
  task automatic do_cmd(input logic [2:0] op, input logic hit, input logic [EW-1:0] rentry,
                        input logic [IW-1:0] sidx, input logic flush_acc);
    logic [2:0]    inv_op_c;
    logic [9:0]    inv_asid_c, asid_c;
    logic [31:0]   inv_vaddr_c, lo0_c, lo1_c;
    logic [IW-1:0] idx_c;
    logic [5:0]    ps_c;
    logic          ne_c, refill_c, illegal, rd_e;
    logic [18:0]   vppn_c;
    logic [EW-1:0] went;
    ent_t          re;
    int            lat, got_lat, we_cnt, inv_cnt;

    inv_op_c = bus.cmd_inv_op;       inv_asid_c = bus.cmd_inv_asid;
    inv_vaddr_c = bus.cmd_inv_vaddr; idx_c = bus.csr_tlbidx_index;
    ps_c = bus.csr_tlbidx_ps;        ne_c = bus.csr_tlbidx_ne;
    vppn_c = bus.csr_tlbehi_vppn;    asid_c = bus.csr_asid;
    lo0_c = bus.csr_tlbelo0;         lo1_c = bus.csr_tlbelo1;
    refill_c = bus.csr_tlbrefill;
    illegal = (op >= 3'd5) || (op == 3'd4 && inv_op_c == 3'd7);
    lat     = (!illegal && op <= 3'd1) ? 3 : 2;
    went    = exp_entry(vppn_c, asid_c, ps_c, ne_c, refill_c, lo0_c, lo1_c);
    re      = rentry;
    rd_e    = re.e;

    chk("cmd_ready_idle", EW'(bus.cmd_ready), EW'(1));
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    bus.flush     = flush_acc;
    tick();
    bus.cmd_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.cmd_op    = 3'($urandom);
    rand_csr();
    bus.tlb_r_entry = rand_ent();
    bus.tlb_s_index = IW'($urandom);
    bus.tlb_rs_e    = 1'($urandom);
    #1;

    we_cnt = 0; inv_cnt = 0; got_lat = 0;
    for (int k = 1; k <= 5 && got_lat == 0; k++) begin
      if (bus.tlb_we)        we_cnt++;
      if (bus.tlb_inv_valid) inv_cnt++;
      if (k == 1) begin
        chk("issue_ready", EW'(bus.cmd_ready), EW'(0));
        chk("issue_we", EW'(bus.tlb_we), EW'(!illegal && (op == 3'd2 || op == 3'd3)));
        chk("issue_inv", EW'(bus.tlb_inv_valid), EW'(!illegal && op == 3'd4));
        if (!illegal && (op == 3'd2 || op == 3'd3)) begin
          chk("w_entry", bus.tlb_w_entry, went);
          chk("fill_mode", EW'(bus.tlb_fill_mode), EW'(op == 3'd3));
        end
        if (!illegal && op == 3'd2) chk("w_index", EW'(bus.tlb_w_index), EW'(idx_c));
        if (!illegal && op == 3'd3) chk("f_index", EW'(bus.tlb_f_index), EW'(exp_fill(n_edges)));
        if (!illegal && op == 3'd4) begin
          chk("inv_op", EW'(bus.tlb_inv_op), EW'(inv_op_c));
          chk("inv_vaddr", EW'(bus.tlb_inv_vaddr), EW'(inv_vaddr_c));
          chk("inv_asid", EW'(bus.tlb_inv_asid), EW'(inv_asid_c));
        end
        if (!illegal && op == 3'd1) begin
          chk("r_index", EW'(bus.tlb_r_index), EW'(idx_c));
          chk("check_mode_rd", EW'(bus.tlb_check_mode), EW'(0));
        end
        if (!illegal && op == 3'd0) begin
          chk("s_vpn2", EW'(bus.tlb_s_vpn2), EW'(vppn_c));
          chk("s_asid", EW'(bus.tlb_s_asid), EW'(asid_c));
          chk("check_mode_srch", EW'(bus.tlb_check_mode), EW'(1));
        end
      end
      if (bus.res_valid) begin
        got_lat = k;
        chk("res_op", EW'(bus.res_op), EW'(op));
        chk("res_err", EW'(bus.res_err), EW'(illegal));
        if (!illegal && op == 3'd0) begin
          chk("srch_ne", EW'(bus.res_ne), EW'(!hit));
          chk("srch_index", EW'(bus.res_index), EW'(hit ? sidx : '0));
        end
        if (!illegal && op == 3'd1) begin
          chk("rd_ne", EW'(bus.res_ne), EW'(!rd_e));
          chk("rd_entry", bus.res_entry, rd_e ? rentry : '0);
        end
      end else begin
        tick();
        if (k == 1) begin
          bus.tlb_r_entry = rentry;
          bus.tlb_s_index = sidx;
          bus.tlb_rs_e    = (op == 3'd0) ? hit : rd_e;
        end
      end
    end
    chk("latency", EW'(got_lat), EW'(lat));
    chk("we_pulses", EW'(we_cnt), EW'(!illegal && (op == 3'd2 || op == 3'd3)));
    chk("inv_pulses", EW'(inv_cnt), EW'(!illegal && op == 3'd4));
    tick();
    chk("res_one_cycle", EW'(bus.res_valid), EW'(0));
    chk("ready_after", EW'(bus.cmd_ready), EW'(1));
    n_txn++;
    $display("txn %0d op=%0d err=%0b lat=%0d we=%0d inv=%0d", n_txn, op, illegal, got_lat,
             we_cnt, inv_cnt);
  endtask

  task automatic flush_wr();
    rand_csr();
    bus.cmd_op    = 3'd2;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.flush     = 1'b1;
    #1;
    chk("flush_we", EW'(bus.tlb_we), EW'(0));
    chk("flush_res", EW'(bus.res_valid), EW'(0));
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_ready", EW'(bus.cmd_ready), EW'(1));
    for (int k = 0; k < 2; k++) begin
      chk("flush_no_res", EW'(bus.res_valid), EW'(0));
      chk("flush_no_we", EW'(bus.tlb_we), EW'(0));
      tick();
    end
    n_txn++;
    $display("txn %0d op=2 flushed in ISSUE", n_txn);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_ready"}, EW'(bus.cmd_ready), EW'(0));
    chk({pfx, "_res_valid"}, EW'(bus.res_valid), EW'(0));
    chk({pfx, "_we"}, EW'(bus.tlb_we), EW'(0));
    chk({pfx, "_inv"}, EW'(bus.tlb_inv_valid), EW'(0));
    chk({pfx, "_w_entry"}, bus.tlb_w_entry, '0);
    chk({pfx, "_r_index"}, EW'(bus.tlb_r_index), EW'(0));
    chk({pfx, "_check_mode"}, EW'(bus.tlb_check_mode), EW'(0));
    chk({pfx, "_s_vpn2"}, EW'(bus.tlb_s_vpn2), EW'(0));
    chk({pfx, "_res_entry"}, bus.res_entry, '0);
    chk({pfx, "_res_ne"}, EW'(bus.res_ne), EW'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [EW-1:0] ent;
    ent_t          et;
    int            guard;
    bus.flush = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd0;
    rand_csr();
    bus.tlb_r_entry = '0;
    bus.tlb_s_index = '0;
    bus.tlb_rs_e = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // FILL issued so its ISSUE cycle is the 40th edge after reset.
    guard = 0;
    while (n_edges != 39 && guard < 100) begin
      tick();
      guard++;
    end
    chk("fill_align", EW'(n_edges), EW'(39));
    rand_csr();
    do_cmd(3'd3, 1'b0, '0, '0, 1'b0);

    rand_csr();
    bus.csr_tlbidx_index = IW'(5);
    bus.csr_tlbehi_vppn  = 19'h1234;
    bus.csr_tlbelo0      = $urandom | 32'h40;
    bus.csr_tlbelo1      = $urandom & ~32'h40;
    bus.csr_tlbidx_ne    = 1'b1;
    bus.csr_tlbrefill    = 1'b0;
    do_cmd(3'd2, 1'b0, '0, '0, 1'b0);

    rand_csr();
    do_cmd(3'd0, 1'b1, rand_ent(), IW'(9), 1'b0);
    rand_csr();
    do_cmd(3'd0, 1'b0, rand_ent(), IW'(17), 1'b0);

    et = rand_ent(); et.e = 1'b0; ent = et;
    rand_csr();
    do_cmd(3'd1, 1'b0, ent, '0, 1'b0);
    et = rand_ent(); et.e = 1'b1; ent = et;
    rand_csr();
    do_cmd(3'd1, 1'b0, ent, '0, 1'b0);

    rand_csr();
    bus.cmd_inv_op = 3'd7;
    do_cmd(3'd4, 1'b0, '0, '0, 1'b0);
    rand_csr();
    bus.cmd_inv_op = 3'd5;
    do_cmd(3'd4, 1'b0, '0, '0, 1'b0);

    flush_wr();
    rand_csr();
    do_cmd(3'd2, 1'b0, '0, '0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      rand_csr();
      do_cmd(3'($urandom_range(0, 7)), 1'($urandom), rand_ent(), IW'($urandom), 1'b0);
    end

    // Reset while a read sits in WAIT: everything drops at once, no result follows.
    rand_csr();
    bus.cmd_op    = 3'd1;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.tlb_r_entry = rand_ent();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", EW'(bus.cmd_ready), EW'(1));
    chk("post_rst_res", EW'(bus.res_valid), EW'(0));
    tick();
    chk("post_rst_res2", EW'(bus.res_valid), EW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
